program_loader: RTL and testbench
=================================

# program_loader

Stream-to-RAM boot loader that writes a program image into the shared RAM through the same `rw`/`address`/`data_in` write port the memory control unit drives. It accepts 32-bit words on a valid/ready stream, writes them to consecutive word addresses, and holds the processor core in reset until the image is complete. It sits in front of the RAM write-port mux, alongside `mem_control_unit`. It is the writer side for the instruction-fetch path that reads through `pc_addr`.

## Interface
Parameters:
- `ADDR_W`, 16: RAM address width.
- `DATA_W`, 32: RAM and stream word width.
- `CNT_W`, 9: width of the word-count input (maximum 256 words, matching the 8-bit PC).

Ports:
- `clk` input 1: the single clock; all logic is on the rising edge.
- `reset` input 1: synchronous, active-high reset.
- `start` input 1: one-cycle pulse that begins a load. Honoured only in IDLE or DONE.
- `base_addr` input ADDR_W: first RAM address. Sampled on an accepted `start`.
- `word_count` input CNT_W: number of payload words. Sampled on an accepted `start`.
- `in_valid` input 1: stream word present.
- `in_data` input DATA_W: stream word.
- `in_ready` output 1: loader can accept a stream word this cycle.
- `rw` output 1: RAM write strobe; 1 = write, 0 = no write from the loader.
- `address` output ADDR_W: RAM write address.
- `data_out` output DATA_W: RAM write data.
- `cpu_reset` output 1: holds the core (PC, instruction register) in reset.
- `busy` output 1: high in LOAD (and CHECK when compiled in).
- `done` output 1: load finished; stays high until the next accepted `start` or `reset`.
- `err` output 1: checksum mismatch. Constant 0 when the feature is compiled out.

## Operation
- **States:** IDLE, LOAD, CHECK (only when the feature is compiled in), DONE.
- **IDLE**
  - `start` with `word_count` = 0: go directly to DONE.
  - `start` with nonzero `word_count`: go to LOAD. Word index clears to 0; `base_addr` and `word_count` are latched.
- **LOAD**
  - `in_ready` = 1 while index < count.
  - A handshake (`in_valid && in_ready`) captures `in_data` and increments the index.
  - When the last payload word is accepted, go to CHECK (feature in) or DONE (feature out).
- **Address arithmetic:** address = latched base + index, modulo 2^ADDR_W. Wrap from 0xFFFF to 0x0000 is silent.
- **DONE**
  - `in_ready` = 0.
  - `cpu_reset` = 0, unless `err` = 1.
  - A new `start` restarts the load. `cpu_reset` re-asserts on the next cycle and `done`/`err` clear.
- **Ignored inputs:** `start` during LOAD or CHECK is ignored. Stream words offered outside LOAD or CHECK are not accepted.
- **Reset mid-load:** go to IDLE, `cpu_reset` = 1, no further writes. A partially written image is left in RAM as is.

## Timing
- **Reset values:** state = IDLE, `in_ready` = 0, `rw` = 0, `address` = 0, `data_out` = 0, `cpu_reset` = 1, `busy` = 0, `done` = 0, `err` = 0.
- **Write latency:** a handshake in cycle N drives `rw` = 1 with the matching `address`/`data_out` in cycle N+1, for exactly one cycle. All outputs are registered.
- **Throughput:** back-to-back handshakes give one write per cycle with no bubbles.
- **`busy`:** asserts the cycle after the accepted `start`.
- **End of load:** `done` rises the cycle after the final write strobe. `cpu_reset` falls in that same cycle, so the core's first fetch sees the complete image.
- **Simultaneous events:** `start` together with `reset` → reset wins.

## Configuration
- **`LOADER_CHECKSUM_EN` defined:**
  - The loader keeps a running 32-bit wrapping sum of the payload words.
  - After the last payload word it enters CHECK. `in_ready` = 1 and one more stream word (the expected sum) is accepted; this word is not written to RAM.
  - Match: DONE with `err` = 0 and `cpu_reset` = 0.
  - Mismatch: DONE with `err` = 1 and `cpu_reset` held at 1.
- **Undefined:** no CHECK state, no sum register, `err` tied to 0.

## Structure
- **Shared package** `processor_pkg`:
  - state enum `loader_state_t`.
  - constants `RAM_ADDR_W` = 16, `WORD_W` = 32, `MAX_PROGRAM_WORDS` = 256.
- **Sub-module:** none required. The FSM, index counter and optional sum register form a single module.

## Test plan
- **Basic load:** `base_addr` = 0x0000, `word_count` = 4, words 0x11,0x22,0x33,0x44 with `in_valid` held high → four consecutive `rw` pulses at addresses 0..3 with matching data; `done` = 1 and `cpu_reset` = 0 one cycle after the last write.
- **Stalled stream:** `word_count` = 3, `in_valid` toggling 1,0,0,1,0,1 → writes only on handshake+1 cycles; addresses 0,1,2 with no gaps in the index sequence.
- **Address wrap:** `base_addr` = 0xFFFE, `word_count` = 3 → writes at 0xFFFE, 0xFFFF, 0x0000.
- **Reset mid-load:** `word_count` = 8, assert `reset` after the 3rd handshake → next cycle IDLE, `rw` = 0, `cpu_reset` = 1, `done` = 0; no further writes despite `in_valid` = 1.
- **Zero count and restart:** `word_count` = 0 → `done` = 1 with no writes. A second `start` with `word_count` = 1 → `done` clears, `cpu_reset` = 1, one write, then `done` = 1.
- **Checksum (`LOADER_CHECKSUM_EN`):**
  - words 1,2,3 then 6 → `err` = 0, `cpu_reset` = 0.
  - words 1,2,3 then 7 → `err` = 1, `cpu_reset` stays 1; only 3 writes in both cases.

Source files
------------

// File: rtl/processor_pkg.sv
// Shared processor definitions: RAM geometry and the boot-loader FSM encoding.
package processor_pkg;

  localparam int RAM_ADDR_W        = 16;
  localparam int WORD_W            = 32;
  localparam int MAX_PROGRAM_WORDS = 256;

  typedef enum logic [1:0] {
    LDR_IDLE  = 2'd0,
    LDR_LOAD  = 2'd1,
    LDR_CHECK = 2'd2,
    LDR_DONE  = 2'd3
  } loader_state_t;

endpackage

// File: rtl/program_loader.sv
// Stream-to-RAM boot loader: writes a word stream to consecutive RAM addresses and holds the core in reset.
// Optional trailing checksum word is enabled with the LOADER_CHECKSUM_EN macro.
module program_loader
  import processor_pkg::*;
#(
  parameter int ADDR_W = RAM_ADDR_W,
  parameter int DATA_W = WORD_W,
  parameter int CNT_W  = $clog2(MAX_PROGRAM_WORDS) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  word_count,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              rw,
  output logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] data_out,
  output logic              cpu_reset,
  output logic              busy,
  output logic              done,
  output logic              err
);

  loader_state_t     state_q, state_d;
  logic [CNT_W-1:0]  idx_q, idx_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic              in_ready_q, in_ready_d;
  logic              rw_q, rw_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              cpu_reset_q, cpu_reset_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
`ifdef LOADER_CHECKSUM_EN
  logic [DATA_W-1:0] sum_q, sum_d;
  logic              fail_q, fail_d;
`endif

  logic start_acc_s;
  logic hs_s;
  logic last_word_s;

  assign start_acc_s = start && ((state_q == LDR_IDLE) || (state_q == LDR_DONE));
  assign hs_s        = in_valid && in_ready_q;
  assign last_word_s = ((idx_q + CNT_W'(1)) == count_q);

  // FSM, index counter, write-port and checksum next-state logic
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    count_d = count_q;
    base_d  = base_q;
    rw_d    = 1'b0;
    addr_d  = addr_q;
    data_d  = data_q;
`ifdef LOADER_CHECKSUM_EN
    sum_d   = sum_q;
    fail_d  = fail_q;
`endif
    case (state_q)
      LDR_IDLE, LDR_DONE: begin
        if (start) begin
          count_d = word_count;
          base_d  = base_addr;
          idx_d   = {CNT_W{1'b0}};
`ifdef LOADER_CHECKSUM_EN
          sum_d   = {DATA_W{1'b0}};
          fail_d  = 1'b0;
`endif
          if (word_count == {CNT_W{1'b0}}) begin
            state_d = LDR_DONE;
          end else begin
            state_d = LDR_LOAD;
          end
        end else begin
          state_d = state_q;
        end
      end
      LDR_LOAD: begin
        if (hs_s) begin
          rw_d   = 1'b1;
          addr_d = base_q + ADDR_W'(idx_q);
          data_d = in_data;
          idx_d  = idx_q + CNT_W'(1);
`ifdef LOADER_CHECKSUM_EN
          sum_d  = sum_q + in_data;
`endif
          if (last_word_s) begin
`ifdef LOADER_CHECKSUM_EN
            state_d = LDR_CHECK;
`else
            state_d = LDR_DONE;
`endif
          end else begin
            state_d = LDR_LOAD;
          end
        end else begin
          state_d = LDR_LOAD;
        end
      end
`ifdef LOADER_CHECKSUM_EN
      LDR_CHECK: begin
        // The expected-sum word is consumed here and never reaches RAM.
        if (hs_s) begin
          fail_d  = (in_data != sum_q);
          state_d = LDR_DONE;
        end else begin
          state_d = LDR_CHECK;
        end
      end
`endif
      default: begin
        state_d = LDR_IDLE;
      end
    endcase
  end

  // Status outputs; done/err trail the state by one cycle so done follows the last write strobe
  always_comb begin
    in_ready_d = (state_d == LDR_LOAD) || (state_d == LDR_CHECK);
    busy_d     = (state_d == LDR_LOAD) || (state_d == LDR_CHECK);
    done_d     = (state_q == LDR_DONE) && !start_acc_s;
`ifdef LOADER_CHECKSUM_EN
    err_d      = done_d && fail_q;
`else
    err_d      = 1'b0;
`endif
    cpu_reset_d = !(done_d && !err_d);
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= LDR_IDLE;
      idx_q       <= {CNT_W{1'b0}};
      count_q     <= {CNT_W{1'b0}};
      base_q      <= {ADDR_W{1'b0}};
      in_ready_q  <= 1'b0;
      rw_q        <= 1'b0;
      addr_q      <= {ADDR_W{1'b0}};
      data_q      <= {DATA_W{1'b0}};
      cpu_reset_q <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      sum_q       <= {DATA_W{1'b0}};
      fail_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      count_q     <= count_d;
      base_q      <= base_d;
      in_ready_q  <= in_ready_d;
      rw_q        <= rw_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      cpu_reset_q <= cpu_reset_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
`ifdef LOADER_CHECKSUM_EN
      sum_q       <= sum_d;
      fail_q      <= fail_d;
`endif
    end
  end

  assign in_ready  = in_ready_q;
  assign rw        = rw_q;
  assign address   = addr_q;
  assign data_out  = data_q;
  assign cpu_reset = cpu_reset_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: randomized loads checked against a queue-based write model.
module tb_program_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] base_addr;
  logic [8:0]  word_count;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_ready, rw, cpu_reset, busy, done, err;
  logic [15:0] address;
  logic [31:0] data_out;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [15:0] wa_q[$];
  logic [31:0] wd_q[$];
  int          wc_q[$];
  logic [15:0] ea_q[$];
  logic [31:0] ed_q[$];
  int          ec_q[$];

  program_loader dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
    .word_count(word_count), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .rw(rw), .address(address), .data_out(data_out),
    .cpu_reset(cpu_reset), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record every write strobe seen by the RAM
  always @(negedge clk) begin
    if (rw === 1'b1) begin
      wa_q.push_back(address);
      wd_q.push_back(data_out);
      wc_q.push_back(cyc);
    end
  end

  task automatic compare_writes(input string name);
    checks++;
    if (wa_q.size() !== ea_q.size()) begin
      errors++;
      $display("FAIL %s write_count: got %0d expected %0d", name, wa_q.size(), ea_q.size());
    end
    for (int k = 0; k < wa_q.size() && k < ea_q.size(); k++) begin
      checks++;
      if (wa_q[k] !== ea_q[k] || wd_q[k] !== ed_q[k] || wc_q[k] !== ec_q[k]) begin
        errors++;
        $display("FAIL %s write[%0d]: got addr=%h data=%h cyc=%0d expected addr=%h data=%h cyc=%0d",
                 name, k, wa_q[k], wd_q[k], wc_q[k], ea_q[k], ed_q[k], ec_q[k]);
      end
    end
  endtask

  // mode: 0 = valid always high, 1 = random valid plus stray start pulses, 2 = valid pattern 1,0,0,1,0,1
  task automatic do_load(input logic [15:0] base, input int n, input int mode,
                         input logic [31:0] step, input bit bad_sum, input string name);
    logic [31:0] words[$];
    logic [31:0] sum;
    logic [5:0]  pat;
    int          total;
    int          i;
    int          budget;
    bit          v;
    bit          exp_err;
    pat = 6'b101001;
    sum = 32'd0;
    for (int k = 0; k < n; k++) begin
      words.push_back((step != 32'd0) ? step * 32'(k + 1) : $urandom);
      sum = sum + words[k];
    end
    wa_q.delete(); wd_q.delete(); wc_q.delete();
    ea_q.delete(); ed_q.delete(); ec_q.delete();
    total = n;
`ifdef LOADER_CHECKSUM_EN
    if (n > 0) total = n + 1;
    exp_err = bad_sum && (n > 0);
`else
    exp_err = 1'b0;
`endif
    start = 1'b1; base_addr = base; word_count = n[8:0]; in_valid = 1'b0;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (done !== 1'b0 || cpu_reset !== 1'b1 || busy !== (n > 0)) begin
      errors++;
      $display("FAIL %s after_start: got done=%b cpu_reset=%b busy=%b expected 0 1 %b",
               name, done, cpu_reset, busy, (n > 0));
    end
    i = 0;
    budget = 0;
    while (i < total && budget < 300) begin
      case (mode)
        0: v = 1'b1;
        1: v = ($urandom_range(0, 1) == 1);
        default: v = pat[budget % 6];
      endcase
      in_valid = v;
      in_data  = (i < n) ? words[i] : (bad_sum ? sum + 32'd1 : sum);
      if (mode == 1 && $urandom_range(0, 7) == 0) begin
        start = 1'b1; base_addr = 16'($urandom); word_count = 9'($urandom);
      end else begin
        start = 1'b0;
      end
      checks++;
      if (in_ready !== 1'b1) begin
        errors++;
        $display("FAIL %s in_ready_load: got %b expected 1", name, in_ready);
      end
      if (v) begin
        if (i < n) begin
          ea_q.push_back(base + 16'(i));
          ed_q.push_back(words[i]);
          ec_q.push_back(cyc + 1);
        end
        i++;
      end
      budget++;
      @(negedge clk);
    end
    start = 1'b0;
    in_valid = 1'b1;
    in_data = $urandom;
    checks++;
    if (i < total) begin
      errors++;
      $display("FAIL %s timeout: got %0d words accepted expected %0d", name, i, total);
    end
    checks++;
    if (in_ready !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL %s end_of_stream: got in_ready=%b done=%b expected 0 0", name, in_ready, done);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || cpu_reset !== exp_err || err !== exp_err || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s done_state: got done=%b cpu_reset=%b err=%b busy=%b expected 1 %b %b 0",
               name, done, cpu_reset, err, busy, exp_err, exp_err);
    end
    repeat (3) @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (done !== 1'b1 || in_ready !== 1'b0 || cpu_reset !== exp_err) begin
      errors++;
      $display("FAIL %s done_hold: got done=%b in_ready=%b cpu_reset=%b expected 1 0 %b",
               name, done, in_ready, cpu_reset, exp_err);
    end
    compare_writes(name);
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b1; base_addr = 16'h1234; word_count = 9'd5;
    in_valid = 1'b1; in_data = 32'hDEADBEEF;
    repeat (3) @(negedge clk);
    checks++;
    if (in_ready !== 1'b0 || rw !== 1'b0 || address !== 16'h0000 || data_out !== 32'h0 ||
        cpu_reset !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
      errors++;
      $display("FAIL reset_values: got rdy=%b rw=%b a=%h d=%h cr=%b busy=%b done=%b err=%b expected 0 0 0 0 1 0 0 0",
               in_ready, rw, address, data_out, cpu_reset, busy, done, err);
    end
    reset = 1'b0; start = 1'b0; in_valid = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || in_ready !== 1'b0 || cpu_reset !== 1'b1) begin
      errors++;
      $display("FAIL idle_after_reset: got busy=%b in_ready=%b cpu_reset=%b expected 0 0 1", busy, in_ready, cpu_reset);
    end
  endtask

  task automatic test_reset_mid_load();
    int hs;
    wa_q.delete(); wd_q.delete(); wc_q.delete();
    start = 1'b1; base_addr = 16'h0100; word_count = 9'd8;
    @(negedge clk);
    start = 1'b0;
    hs = 0;
    for (int k = 0; k < 20 && hs < 3; k++) begin
      in_valid = 1'b1; in_data = $urandom;
      if (in_ready === 1'b1) hs++;
      @(negedge clk);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if (rw !== 1'b0 || cpu_reset !== 1'b1 || done !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_load: got rw=%b cpu_reset=%b done=%b busy=%b in_ready=%b expected 0 1 0 0 0",
               rw, cpu_reset, done, busy, in_ready);
    end
    repeat (5) @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (wa_q.size() !== 3) begin
      errors++;
      $display("FAIL reset_mid_load_writes: got %0d expected 3", wa_q.size());
    end
  endtask

  task automatic test_basic();
    do_load(16'h0000, 4, 0, 32'h11, 1'b0, "basic");
  endtask

  task automatic test_stall();
    do_load(16'h0000, 3, 2, 32'd0, 1'b0, "stall");
  endtask

  task automatic test_wrap();
    do_load(16'hFFFE, 3, 0, 32'd0, 1'b0, "wrap");
  endtask

  task automatic test_zero_restart();
    do_load(16'h0040, 0, 0, 32'd0, 1'b0, "zero_count");
    do_load(16'h0040, 1, 0, 32'd0, 1'b0, "restart_one");
  endtask

  task automatic test_checksum();
    do_load(16'h0200, 3, 0, 32'd1, 1'b0, "checksum_good");
    do_load(16'h0200, 3, 0, 32'd1, 1'b1, "checksum_bad");
  endtask

  task automatic test_back_to_back();
    do_load(16'($urandom), 16, 0, 32'd0, 1'b0, "back_to_back_a");
    do_load(16'($urandom), 256, 0, 32'd0, 1'b0, "back_to_back_max");
  endtask

  task automatic test_random();
    for (int r = 0; r < 8; r++) begin
      do_load(16'($urandom), $urandom_range(1, 20), 1, 32'd0, ($urandom_range(0, 1) == 1), "random");
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_wrap();
    test_reset_mid_load();
    test_zero_restart();
    test_checksum();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
